// File: rtl/spi_regbank_pkg.sv
// spi_regbank_pkg: shared FSM states and command-byte layout for spi_regbank_burst
package spi_regbank_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;
    localparam int CMD_BITS   = 8;
    localparam int CMD_WR_BIT = 7;
    localparam int ADDR_W     = 7;
endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect: per-mode SPI sample/shift strobe generator
// Ports: clk, rstb (async active-low), mode_i {CPOL,CPHA}, spi_clk_i (SPI clock already synchronised to clk),
//        sample_o / shift_o one-clk strobes on the data sample / data shift edge.
module spi_edge_detect (
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] mode_i,
    input  logic       spi_clk_i,
    output logic       sample_o,
    output logic       shift_o
);
    logic sclk_q;
    logic rise;
    logic fall;
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sclk_q <= 1'b0;
        else sclk_q <= spi_clk_i;
    end
    assign rise = spi_clk_i & ~sclk_q;
    assign fall = ~spi_clk_i & sclk_q;
    // modes 0 and 3 sample on rising edges, modes 1 and 2 on falling edges
    assign sample_o = (mode_i[1] ^ mode_i[0]) ? fall : rise;
    assign shift_o  = (mode_i[1] ^ mode_i[0]) ? rise : fall;
endmodule

// File: rtl/spi_regbank_burst.sv
// spi_regbank_burst: SPI slave register bank with auto-incrementing burst read/write
// Ports: clk, rstb (async active-low), ena (unused power flag), mode {CPOL,CPHA},
//        spi_cs_n/spi_clk/spi_mosi (synchronised SPI inputs), spi_miso (read data, MSB first),
//        config_regs (flat R/W bank), status_regs (flat read-only bank),
//        cfg_wr_pulse/cfg_wr_addr (strobe and index of each committed config write).
module spi_regbank_burst #(
    parameter int                   NUM_CFG       = 8,
    parameter int                   NUM_STATUS    = 8,
    parameter int                   REG_WIDTH     = 8,
    parameter logic [REG_WIDTH-1:0] CFG_RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic [1:0]                      mode,
    input  logic                            spi_cs_n,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic                            cfg_wr_pulse,
    output logic [6:0]                      cfg_wr_addr
);
    import spi_regbank_pkg::*;
    localparam int RX_W = (REG_WIDTH > CMD_BITS) ? REG_WIDTH : CMD_BITS;
    localparam int CNT_W = $clog2(RX_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CFG + NUM_STATUS - 1);
    localparam logic [ADDR_W:0] CFG_END = (ADDR_W + 1)'(NUM_CFG);
    state_e                state_q;
    logic                  cs_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [RX_W-2:0]       rx_q;
    logic [REG_WIDTH-1:0]  tx_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wr_q;
    logic                  miso_q;
    logic                  pulse_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [REG_WIDTH-1:0]  cfg_q [NUM_CFG];
    logic                  sample;
    logic                  shift;
    logic [CMD_BITS-1:0]   cmd_d;
    logic [REG_WIDTH-1:0]  word_d;
    logic [ADDR_W-1:0]     addr_inc_d;
    logic [ADDR_W-1:0]     rd_addr_d;
    logic [REG_WIDTH-1:0]  rd_word_d;
    logic                  unused_ena;
    assign unused_ena = ena;
    spi_edge_detect u_edge (
        .clk       (clk),
        .rstb      (rstb),
        .mode_i    (mode),
        .spi_clk_i (spi_clk),
        .sample_o  (sample),
        .shift_o   (shift)
    );
    assign cmd_d      = {rx_q[CMD_BITS-2:0], spi_mosi};
    assign word_d     = {rx_q[REG_WIDTH-2:0], spi_mosi};
    assign addr_inc_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    // the word that becomes current after this sample: the start address at the end of the command,
    // otherwise the next burst address; status is snapshotted here, unmapped addresses read zero
    always_comb begin
        rd_addr_d = (state_q == CMD) ? cmd_d[ADDR_W-1:0] : addr_inc_d;
        rd_word_d = '0;
        for (int i = 0; i < NUM_CFG; i++)
            if (rd_addr_d == ADDR_W'(i)) rd_word_d = cfg_q[i];
        for (int i = 0; i < NUM_STATUS; i++)
            if (rd_addr_d == ADDR_W'(NUM_CFG + i)) rd_word_d = status_regs[i*REG_WIDTH +: REG_WIDTH];
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            cs_q      <= 1'b0;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            miso_q    <= 1'b0;
            pulse_q   <= 1'b0;
            wr_addr_q <= '0;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RESET_VAL;
        end else begin
            // cs_q resets low so a frame already in progress at reset release is ignored
            cs_q    <= spi_cs_n;
            pulse_q <= 1'b0;
            if (spi_cs_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cs_q) begin
                            state_q <= CMD;
                            cnt_q   <= '0;
                        end
                    end
                    CMD: begin
                        if (sample) begin
                            rx_q  <= {rx_q[RX_W-3:0], spi_mosi};
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                                state_q <= DATA;
                                cnt_q   <= '0;
                                wr_q    <= cmd_d[CMD_WR_BIT];
                                addr_q  <= cmd_d[ADDR_W-1:0];
                                tx_q    <= cmd_d[CMD_WR_BIT] ? '0 : rd_word_d;
                            end
                        end
                    end
                    DATA: begin
                        // one shift per bit; the word loaded at the previous sample is presented on the
                        // following shift edge, which is before the first sample for both CPHA values
                        if (shift && !wr_q) begin
                            miso_q <= tx_q[REG_WIDTH-1];
                            tx_q   <= {tx_q[REG_WIDTH-2:0], 1'b0};
                        end
                        if (sample) begin
                            rx_q  <= {rx_q[RX_W-3:0], spi_mosi};
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(REG_WIDTH - 1)) begin
                                cnt_q  <= '0;
                                addr_q <= addr_inc_d;
                                if (!wr_q) tx_q <= rd_word_d;
                                if (wr_q && ({1'b0, addr_q} < CFG_END)) begin
                                    for (int i = 0; i < NUM_CFG; i++)
                                        if (addr_q == ADDR_W'(i)) cfg_q[i] <= word_d;
                                    pulse_q   <= 1'b1;
                                    wr_addr_q <= addr_q;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
        assign config_regs[g*REG_WIDTH +: REG_WIDTH] = cfg_q[g];
    end
    assign spi_miso     = miso_q & ~spi_cs_n;
    assign cfg_wr_pulse = pulse_q;
    assign cfg_wr_addr  = wr_addr_q;
endmodule
